hazard_sched: RTL and testbench

//  Pipeline hazard scheduler; sequences the IF/ID, D/E, E/M and M/W registers of the 5-stage RV32IF core.

---
 rtl/hazard_sched_pkg.sv | 17 +
 rtl/hazard_sched_md_timer.sv | 42 ++++
 rtl/hazard_sched.sv | 167 ++++++++++++++++
 tb/tb_hazard_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sched_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
package hazard_sched_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hs_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Width of the MUL/DIV occupancy down-counter. The largest value it holds is
    // MD_LATENCY-2, and it is never narrower than one bit.
    function automatic int unsigned md_cnt_width(input int unsigned latency);
        return (latency > 2) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/hazard_sched_md_timer.sv
// Down-counter that tracks the remaining EX occupancy of a MUL/DIV op.
// It loads, decrements toward zero, or holds while the pipeline is frozen.
module hazard_sched_md_timer
    import hazard_sched_pkg::*;
#(
    parameter int unsigned W = md_cnt_width(32)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    input  logic         freeze_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: freeze wins, then load, then decrement (stops at zero).
    always_comb begin
        cnt_d = cnt_q;
        if (!freeze_i) begin
            if (load_i) begin
                cnt_d = load_val_i;
            end else if (dec_i && (cnt_q != '0)) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage RV32IF pipeline: produces hold / bubble /
// flush controls for IF/ID, D/E, E/M and M/W from load-use, mispredict,
// multi-cycle MUL/DIV and DMEM-wait conditions, and counts stalls and flushes.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        D_rs1,
    input  logic [4:0]        D_rs2,
    input  logic              D_use_rs1,
    input  logic              D_use_rs2,
    input  logic [4:0]        D_rs1_f,
    input  logic [4:0]        D_rs2_f,
    input  logic              D_use_rs1_f,
    input  logic              D_use_rs2_f,
    input  logic [4:0]        E_rd,
    input  logic [4:0]        E_rd_f,
    input  logic              E_load,
    input  logic              E_load_f,
    input  logic              E_mispredict,
    input  logic              E_md_start,
    input  logic              M_dmem_req,
    input  logic              M_dmem_ready,
    output logic              pc_hold,
    output logic              fd_hold,
    output logic              fd_flush,
    output logic              de_hold,
    output logic              de_bubble,
    output logic              em_hold,
    output logic              em_bubble,
    output logic              mw_bubble,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    localparam int unsigned CW        = md_cnt_width(MD_LATENCY);
    localparam bit          MD_STALLS = (MD_LATENCY > 1);
    // First EX cycle is spent in RUN, the last one at count zero.
    localparam int unsigned MD_LOAD_I = MD_STALLS ? (MD_LATENCY - 2) : 0;
    localparam logic [CW-1:0] MD_LOAD = MD_LOAD_I[CW-1:0];

    hs_state_e state_q, state_d;

    logic freeze;
    logic load_use;
    logic md_load, md_dec, md_zero;
    logic flush_evt;

    logic [PERF_W-1:0] stall_q, stall_d;
    logic [PERF_W-1:0] flush_q, flush_d;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + PERF_W'(1) : v;
    endfunction

    hazard_sched_md_timer #(
        .W (CW)
    ) u_md_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (md_load),
        .load_val_i (MD_LOAD),
        .dec_i      (md_dec),
        .freeze_i   (freeze),
        .zero_o     (md_zero)
    );

    // A DMEM access that has not completed stalls everything behind MEM.
    assign freeze = M_dmem_req & ~M_dmem_ready;

    // Load-use hazard: x0 never creates a dependency, f0 is a real register.
    always_comb begin
        load_use = 1'b0;
        if (E_load && (E_rd != REG_X0) &&
            ((D_use_rs1 && (D_rs1 == E_rd)) || (D_use_rs2 && (D_rs2 == E_rd)))) begin
            load_use = 1'b1;
        end
        if (E_load_f &&
            ((D_use_rs1_f && (D_rs1_f == E_rd_f)) || (D_use_rs2_f && (D_rs2_f == E_rd_f)))) begin
            load_use = 1'b1;
        end
    end

    // FSM next state and priority-ordered pipeline controls.
    always_comb begin
        state_d   = state_q;
        md_load   = 1'b0;
        md_dec    = 1'b0;
        flush_evt = 1'b0;
        pc_hold   = 1'b0;
        fd_hold   = 1'b0;
        fd_flush  = 1'b0;
        de_hold   = 1'b0;
        de_bubble = 1'b0;
        em_hold   = 1'b0;
        em_bubble = 1'b0;
        mw_bubble = 1'b0;
        if (rst) begin
            state_d = RUN;
        end else if (freeze) begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            de_hold   = 1'b1;
            em_hold   = 1'b1;
            mw_bubble = 1'b1;
        end else if (state_q == MD_BUSY) begin
            pc_hold = 1'b1;
            fd_hold = 1'b1;
            de_hold = 1'b1;
            if (!md_zero) begin
                em_bubble = 1'b1;
                md_dec    = 1'b1;
            end else begin
                // Final EX cycle: the MUL/DIV result moves on to MEM.
                state_d = RUN;
            end
        end else if (E_mispredict) begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            flush_evt = 1'b1;
        end else if (E_md_start && MD_STALLS) begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            de_hold   = 1'b1;
            em_bubble = 1'b1;
            md_load   = 1'b1;
            state_d   = MD_BUSY;
        end else if (load_use) begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            de_bubble = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall_d = sat_inc(stall_q, pc_hold);
    assign flush_d = sat_inc(flush_q, flush_evt);

    // Saturating stall and flush performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign md_busy   = (state_q == MD_BUSY);
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_hazard_sched;

    localparam int L    = 4;
    localparam int PW   = 5;
    localparam int PMAX = (1 << PW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] D_rs1, D_rs2, D_rs1_f, D_rs2_f, E_rd, E_rd_f;
    logic D_use_rs1, D_use_rs2, D_use_rs1_f, D_use_rs2_f;
    logic E_load, E_load_f, E_mispredict, E_md_start, M_dmem_req, M_dmem_ready;
    logic pc_hold, fd_hold, fd_flush, de_hold, de_bubble, em_hold, em_bubble, mw_bubble, md_busy;
    logic [PW-1:0] stall_cnt, flush_cnt;
    logic [8:0] outv;

    int checks   = 0;
    int failures = 0;

    // Model state: EX cycles already spent by the MUL/DIV in flight (0 = none).
    int m_occ   = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    hazard_sched #(.MD_LATENCY(L), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst),
        .D_rs1(D_rs1), .D_rs2(D_rs2), .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2),
        .D_rs1_f(D_rs1_f), .D_rs2_f(D_rs2_f), .D_use_rs1_f(D_use_rs1_f), .D_use_rs2_f(D_use_rs2_f),
        .E_rd(E_rd), .E_rd_f(E_rd_f), .E_load(E_load), .E_load_f(E_load_f),
        .E_mispredict(E_mispredict), .E_md_start(E_md_start),
        .M_dmem_req(M_dmem_req), .M_dmem_ready(M_dmem_ready),
        .pc_hold(pc_hold), .fd_hold(fd_hold), .fd_flush(fd_flush),
        .de_hold(de_hold), .de_bubble(de_bubble), .em_hold(em_hold),
        .em_bubble(em_bubble), .mw_bubble(mw_bubble), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Bit order: pc_hold fd_hold fd_flush de_hold de_bubble em_hold em_bubble mw_bubble md_busy
    assign outv = {pc_hold, fd_hold, fd_flush, de_hold, de_bubble, em_hold, em_bubble, mw_bubble, md_busy};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_freeze();
        return M_dmem_req && !M_dmem_ready;
    endfunction

    function automatic bit m_load_use();
        bit hit_i, hit_f;
        hit_i = E_load && (E_rd != 5'd0) &&
                ((D_use_rs1 && D_rs1 == E_rd) || (D_use_rs2 && D_rs2 == E_rd));
        hit_f = E_load_f && ((D_use_rs1_f && D_rs1_f == E_rd_f) || (D_use_rs2_f && D_rs2_f == E_rd_f));
        return hit_i || hit_f;
    endfunction

    // Expected control outputs from the scheduling rules and the model state.
    function automatic logic [8:0] model_out();
        logic pc, fd, ff, dh, db, eh, eb, mw;
        {pc, fd, ff, dh, db, eh, eb, mw} = 8'b0;
        if (rst) return 9'b0;
        if (m_freeze()) begin
            pc = 1; fd = 1; dh = 1; eh = 1; mw = 1;
        end else if (m_occ > 0) begin
            pc = 1; fd = 1; dh = 1;
            eb = (m_occ + 1 < L);
        end else if (E_mispredict) begin
            ff = 1; db = 1;
        end else if (E_md_start && L > 1) begin
            pc = 1; fd = 1; dh = 1; eb = 1;
        end else if (m_load_use()) begin
            pc = 1; fd = 1; db = 1;
        end
        return {pc, fd, ff, dh, db, eh, eb, mw, 1'(m_occ > 0)};
    endfunction

    function automatic int next_occ();
        int n;
        n = m_occ;
        if (m_freeze()) return n;
        if (n > 0) begin
            n = n + 1;
            if (n == L) n = 0;
        end else if (!E_mispredict && E_md_start && L > 1) begin
            n = 1;
        end
        return n;
    endfunction

    function automatic int next_stall();
        logic [8:0] e;
        e = model_out();
        return (e[8] && m_stall < PMAX) ? m_stall + 1 : m_stall;
    endfunction

    function automatic int next_flush();
        if (!m_freeze() && m_occ == 0 && E_mispredict && m_flush < PMAX) return m_flush + 1;
        return m_flush;
    endfunction

    // Advance the model on each active edge.
    always @(posedge clk) begin
        m_occ   <= rst ? 0 : next_occ();
        m_stall <= rst ? 0 : next_stall();
        m_flush <= rst ? 0 : next_flush();
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        assert (!(E_mispredict && E_md_start));
        chk("model_outs", 32'(outv), 32'(model_out()));
        chk("model_stall_cnt", 32'(stall_cnt), rst ? 32'd0 : 32'(m_stall));
        chk("model_flush_cnt", 32'(flush_cnt), rst ? 32'd0 : 32'(m_flush));
    end

    task automatic idle();
        D_rs1 = 0; D_rs2 = 0; D_rs1_f = 0; D_rs2_f = 0; E_rd = 0; E_rd_f = 0;
        D_use_rs1 = 0; D_use_rs2 = 0; D_use_rs1_f = 0; D_use_rs2_f = 0;
        E_load = 0; E_load_f = 0; E_mispredict = 0; E_md_start = 0;
        M_dmem_req = 0; M_dmem_ready = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        look();
        chk("reset_outs", 32'(outv), 32'd0);
        chk("reset_stall", 32'(stall_cnt), 32'd0);
        chk("reset_flush", 32'(flush_cnt), 32'd0);
        next(); rst = 1'b0;
        look(); chk("idle_outs", 32'(outv), 32'd0);

        // lw x5 followed by a consumer of x5
        next(); E_load = 1; E_rd = 5; D_use_rs1 = 1; D_rs1 = 5;
        look(); chk("lu_int_stall", 32'(outv), 32'(9'b110010000));
        chk("lu_int_stall_cnt", 32'(stall_cnt), 32'd0);
        next(); idle();
        look(); chk("lu_int_clear", 32'(outv), 32'd0);
        chk("lu_int_stall_cnt1", 32'(stall_cnt), 32'd1);
        // x0 destination is exempt
        next(); E_load = 1; E_rd = 0; D_use_rs1 = 1; D_rs1 = 0;
        look(); chk("lu_x0_none", 32'(outv), 32'd0);
        // f0 destination is not exempt
        next(); idle(); E_load_f = 1; E_rd_f = 0; D_use_rs1_f = 1; D_rs1_f = 0;
        look(); chk("lu_f0_stall", 32'(outv), 32'(9'b110010000));
        // mispredict overrides load-use
        next(); idle(); E_mispredict = 1; E_load = 1; E_rd = 5; D_use_rs1 = 1; D_rs1 = 5;
        look(); chk("mispred_outs", 32'(outv), 32'(9'b001010000));
        chk("mispred_flush0", 32'(flush_cnt), 32'd0);
        chk("mispred_stall2", 32'(stall_cnt), 32'd2);
        next(); idle();
        look(); chk("mispred_flush1", 32'(flush_cnt), 32'd1);

        // clear counters
        next(); rst = 1'b1;
        look(); chk("rst2_stall", 32'(stall_cnt), 32'd0);
        next(); rst = 1'b0;

        // MUL/DIV, latency 4
        next(); E_md_start = 1;
        look(); chk("md_c1", 32'(outv), 32'(9'b110100100));
        next(); E_md_start = 0;
        look(); chk("md_c2", 32'(outv), 32'(9'b110100101));
        next(); look(); chk("md_c3", 32'(outv), 32'(9'b110100101));
        next(); look(); chk("md_c4", 32'(outv), 32'(9'b110100001));
        next(); look(); chk("md_done", 32'(outv), 32'd0);
        chk("md_stall4", 32'(stall_cnt), 32'd4);

        // MUL/DIV stretched by a two-cycle DMEM wait
        next(); E_md_start = 1;
        look(); chk("mdf_c1", 32'(outv), 32'(9'b110100100));
        next(); E_md_start = 0;
        look(); chk("mdf_c2", 32'(outv), 32'(9'b110100101));
        next(); M_dmem_req = 1; M_dmem_ready = 0;
        look(); chk("mdf_frz1", 32'(outv), 32'(9'b110101011));
        next(); look(); chk("mdf_frz2", 32'(outv), 32'(9'b110101011));
        next(); M_dmem_req = 0;
        look(); chk("mdf_c3", 32'(outv), 32'(9'b110100101));
        next(); look(); chk("mdf_c4", 32'(outv), 32'(9'b110100001));
        next(); look(); chk("mdf_done", 32'(outv), 32'd0);
        chk("mdf_stall10", 32'(stall_cnt), 32'd10);

        // reset in the middle of MD_BUSY
        next(); E_md_start = 1;
        next(); E_md_start = 0;
        look(); chk("mdr_busy", 32'(outv), 32'(9'b110100101));
        next(); rst = 1'b1;
        look(); chk("mdr_rst_outs", 32'(outv), 32'd0);
        chk("mdr_rst_stall", 32'(stall_cnt), 32'd0);
        next(); rst = 1'b0; E_md_start = 1;
        look(); chk("mdr_c1", 32'(outv), 32'(9'b110100100));
        next(); E_md_start = 0;
        look(); chk("mdr_c2", 32'(outv), 32'(9'b110100101));
        next(); look(); chk("mdr_c3", 32'(outv), 32'(9'b110100101));
        next(); look(); chk("mdr_c4", 32'(outv), 32'(9'b110100001));
        next(); look(); chk("mdr_stall4", 32'(stall_cnt), 32'd4);

        // counter saturation
        next(); M_dmem_req = 1; M_dmem_ready = 0;
        repeat (40) next();
        look(); chk("sat_frz_outs", 32'(outv), 32'(9'b110101010));
        chk("sat_stall", 32'(stall_cnt), 32'(PMAX));
        next(); idle(); E_mispredict = 1;
        repeat (40) next();
        look(); chk("sat_flush", 32'(flush_cnt), 32'(PMAX));
        next(); idle();

        // randomized traffic, checked by the model
        for (int i = 0; i < 3000; i++) begin
            next();
            rst          = ($urandom_range(0, 199) == 0);
            D_rs1        = 5'($urandom_range(0, 3));
            D_rs2        = 5'($urandom_range(0, 3));
            D_rs1_f      = 5'($urandom_range(0, 3));
            D_rs2_f      = 5'($urandom_range(0, 3));
            E_rd         = 5'($urandom_range(0, 3));
            E_rd_f       = 5'($urandom_range(0, 3));
            D_use_rs1    = 1'($urandom_range(0, 1));
            D_use_rs2    = 1'($urandom_range(0, 1));
            D_use_rs1_f  = 1'($urandom_range(0, 1));
            D_use_rs2_f  = 1'($urandom_range(0, 1));
            E_load       = ($urandom_range(0, 2) == 0);
            E_load_f     = ($urandom_range(0, 3) == 0);
            E_mispredict = ($urandom_range(0, 9) == 0);
            E_md_start   = !E_mispredict && ($urandom_range(0, 7) == 0);
            M_dmem_req   = ($urandom_range(0, 3) == 0);
            M_dmem_ready = 1'($urandom_range(0, 1));
        end
        next(); idle(); rst = 1'b0;
        look();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
